// File: rtl/fp_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_div_seq
//  Description : Iterative IEEE-754 single-precision divider, z = x / y.
//                Radix-2 restoring division, one quotient bit per cycle,
//                start/done handshake, IEEE rounding modes and exception
//                flags (invalid, divide-by-zero, overflow, underflow,
//                inexact, zero). Subnormal operands are flushed to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             Sx,
    input  logic             Sy,
    input  logic [EXP_W-1:0] Ex,
    input  logic [EXP_W-1:0] Ey,
    input  logic [MAN_W-1:0] Mx,
    input  logic [MAN_W-1:0] My,
    input  logic [1:0]       R_mode,
    output logic             busy,
    output logic             done,
    output logic             Sz,
    output logic [EXP_W-1:0] Ez,
    output logic [MAN_W-1:0] Mz,
    output logic             invalid_flag,
    output logic             divzero_flag,
    output logic             overflow_flag,
    output logic             underflow_flag,
    output logic             inexact_flag,
    output logic             zero_flag
);

    // Quotient carries the integer bit, MAN_W fraction bits, guard and round.
    localparam int c_q_w   = MAN_W + 3;
    localparam int c_sig_w = MAN_W + 1;
    localparam int c_e_w   = EXP_W + 2;
    localparam int c_cnt_w = $clog2(c_q_w);

    localparam logic [c_cnt_w-1:0]      c_last_iter = c_cnt_w'(c_q_w - 1);
    localparam logic signed [c_e_w-1:0] c_e_one     = c_e_w'(1);
    localparam logic signed [c_e_w-1:0] c_e_zero    = '0;
    localparam logic signed [c_e_w-1:0] c_e_ovf     = c_e_w'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0]        c_e_maxfin  = EXP_W'((1 << EXP_W) - 2);
    localparam logic [MAN_W-1:0]        c_qnan_m    = {1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DIVIDE  = 3'd1,
        ST_ROUND   = 3'd2,
        ST_SPECIAL = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched operand information
    logic                      r_sign;
    logic [1:0]                r_rmode;
    logic signed [c_e_w-1:0]   r_exp;
    logic [c_sig_w:0]          r_rem;
    logic [c_sig_w-1:0]        r_div;
    logic [c_q_w-1:0]          r_q;
    logic [c_cnt_w-1:0]        r_cnt;
    logic                      r_x_zero, r_x_inf, r_x_nan, r_x_snan;
    logic                      r_y_zero, r_y_inf, r_y_nan, r_y_snan;

    // Result registers
    logic                      r_sz;
    logic [EXP_W-1:0]          r_ez;
    logic [MAN_W-1:0]          r_mz;
    logic                      r_invalid, r_divzero, r_overflow, r_underflow, r_inexact, r_zero;

    // Input operand classification
    logic w_x_emin, w_x_emax, w_y_emin, w_y_emax, w_in_special;
    logic signed [c_e_w-1:0] w_exp_in;

    assign w_x_emin     = (Ex == '0);
    assign w_x_emax     = (Ex == '1);
    assign w_y_emin     = (Ey == '0);
    assign w_y_emax     = (Ey == '1);
    assign w_in_special = w_x_emin | w_x_emax | w_y_emin | w_y_emax;
    assign w_exp_in     = $signed({2'b00, Ex}) - $signed({2'b00, Ey}) + $signed(c_e_w'(BIAS));

    // Restoring step: remainder stays below twice the divisor, so the
    // subtracted value always fits back into the remainder register.
    logic             w_rem_ge;
    logic [c_sig_w:0] w_rem_sub;

    assign w_rem_ge  = (r_rem >= {1'b0, r_div});
    assign w_rem_sub = r_rem - {1'b0, r_div};

    // Normalisation, rounding and overflow/underflow resolution
    logic                    w_norm, w_g, w_s, w_inc, w_ovf, w_unf, w_ovf_inf;
    logic [MAN_W-1:0]        w_frac;
    logic [MAN_W:0]          w_sum;
    logic signed [c_e_w-1:0] w_e_adj, w_e_fin;
    logic [EXP_W-1:0]        w_rnd_ez;
    logic [MAN_W-1:0]        w_rnd_mz;

    // Round the quotient according to the latched rounding mode
    always_comb begin
        w_norm = r_q[c_q_w-1];
        if (w_norm) begin
            w_frac  = r_q[c_q_w-2 -: MAN_W];
            w_g     = r_q[1];
            w_s     = r_q[0] | (|r_rem);
            w_e_adj = r_exp;
        end else begin
            w_frac  = r_q[c_q_w-3 -: MAN_W];
            w_g     = r_q[0];
            w_s     = |r_rem;
            w_e_adj = r_exp - c_e_one;
        end
        case (r_rmode)
            2'b00:   w_inc = w_g & (w_s | w_frac[0]);
            2'b01:   w_inc = 1'b0;
            2'b10:   w_inc = (w_g | w_s) & ~r_sign;
            default: w_inc = (w_g | w_s) & r_sign;
        endcase
        w_sum     = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_inc};
        w_e_fin   = w_sum[MAN_W] ? (w_e_adj + c_e_one) : w_e_adj;
        w_ovf     = (w_e_fin >= c_e_ovf);
        w_unf     = !w_ovf && (w_e_fin <= c_e_zero);
        w_ovf_inf = (r_rmode == 2'b00) | ((r_rmode == 2'b10) & ~r_sign) |
                    ((r_rmode == 2'b11) & r_sign);
        w_rnd_ez  = w_e_fin[EXP_W-1:0];
        w_rnd_mz  = w_sum[MAN_W-1:0];
        if (w_ovf) begin
            w_rnd_ez = w_ovf_inf ? '1 : c_e_maxfin;
            w_rnd_mz = w_ovf_inf ? '0 : '1;
        end else if (w_unf) begin
            w_rnd_ez = '0;
            w_rnd_mz = '0;
        end
    end

    // Special-operand result selection
    logic             w_sp_sz, w_sp_invalid, w_sp_divzero, w_sp_zero;
    logic [EXP_W-1:0] w_sp_ez;
    logic [MAN_W-1:0] w_sp_mz;

    // Resolve NaN / infinity / zero operand combinations in priority order
    always_comb begin
        w_sp_sz      = r_sign;
        w_sp_ez      = '0;
        w_sp_mz      = '0;
        w_sp_invalid = 1'b0;
        w_sp_divzero = 1'b0;
        w_sp_zero    = 1'b0;
        if (r_x_nan | r_y_nan) begin
            w_sp_sz      = 1'b0;
            w_sp_ez      = '1;
            w_sp_mz      = c_qnan_m;
            w_sp_invalid = r_x_snan | r_y_snan;
        end else if ((r_x_zero & r_y_zero) | (r_x_inf & r_y_inf)) begin
            w_sp_sz      = 1'b0;
            w_sp_ez      = '1;
            w_sp_mz      = c_qnan_m;
            w_sp_invalid = 1'b1;
        end else if (r_y_zero & ~r_x_inf) begin
            w_sp_ez      = '1;
            w_sp_divzero = 1'b1;
        end else if (r_x_inf) begin
            w_sp_ez      = '1;
        end else begin
            w_sp_zero    = 1'b1;
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = w_in_special ? ST_SPECIAL : ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                busy = 1'b1;
                if (r_cnt == c_last_iter) begin
                    w_next = ST_ROUND;
                end
            end
            ST_ROUND: begin
                busy   = 1'b1;
                w_next = ST_DONE;
            end
            ST_SPECIAL: begin
                busy   = 1'b1;
                w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand capture, quotient iteration and result registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sign      <= 1'b0;
            r_rmode     <= '0;
            r_exp       <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_x_zero    <= 1'b0;
            r_x_inf     <= 1'b0;
            r_x_nan     <= 1'b0;
            r_x_snan    <= 1'b0;
            r_y_zero    <= 1'b0;
            r_y_inf     <= 1'b0;
            r_y_nan     <= 1'b0;
            r_y_snan    <= 1'b0;
            r_sz        <= 1'b0;
            r_ez        <= '0;
            r_mz        <= '0;
            r_invalid   <= 1'b0;
            r_divzero   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_inexact   <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sign      <= Sx ^ Sy;
                        r_rmode     <= R_mode;
                        r_exp       <= w_exp_in;
                        r_rem       <= {2'b01, Mx};
                        r_div       <= {1'b1, My};
                        r_q         <= '0;
                        r_cnt       <= '0;
                        r_x_zero    <= w_x_emin;
                        r_x_inf     <= w_x_emax & (Mx == '0);
                        r_x_nan     <= w_x_emax & (Mx != '0);
                        r_x_snan    <= w_x_emax & (Mx != '0) & ~Mx[MAN_W-1];
                        r_y_zero    <= w_y_emin;
                        r_y_inf     <= w_y_emax & (My == '0);
                        r_y_nan     <= w_y_emax & (My != '0);
                        r_y_snan    <= w_y_emax & (My != '0) & ~My[MAN_W-1];
                        r_invalid   <= 1'b0;
                        r_divzero   <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                        r_inexact   <= 1'b0;
                        r_zero      <= 1'b0;
                    end
                end
                ST_DIVIDE: begin
                    r_q   <= {r_q[c_q_w-2:0], w_rem_ge};
                    r_rem <= w_rem_ge ? {w_rem_sub[c_sig_w-1:0], 1'b0}
                                      : {r_rem[c_sig_w-1:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_ROUND: begin
                    r_sz        <= r_sign;
                    r_ez        <= w_rnd_ez;
                    r_mz        <= w_rnd_mz;
                    r_overflow  <= w_ovf;
                    r_underflow <= w_unf;
                    r_inexact   <= w_g | w_s | w_ovf | w_unf;
                    r_zero      <= w_unf;
                end
                ST_SPECIAL: begin
                    r_sz      <= w_sp_sz;
                    r_ez      <= w_sp_ez;
                    r_mz      <= w_sp_mz;
                    r_invalid <= w_sp_invalid;
                    r_divzero <= w_sp_divzero;
                    r_zero    <= w_sp_zero;
                end
                default: ;
            endcase
        end
    end

    assign Sz             = r_sz;
    assign Ez             = r_ez;
    assign Mz             = r_mz;
    assign invalid_flag   = r_invalid;
    assign divzero_flag   = r_divzero;
    assign overflow_flag  = r_overflow;
    assign underflow_flag = r_underflow;
    assign inexact_flag   = r_inexact;
    assign zero_flag      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_div_seq
//  Description : Self-checking bench for fp_div_seq: directed vector table,
//                handshake/reset sequences and randomized operands checked
//                against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_div_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        Sx, Sy;
    logic [7:0]  Ex, Ey;
    logic [22:0] Mx, My;
    logic [1:0]  R_mode;
    logic        busy, done, Sz;
    logic [7:0]  Ez;
    logic [22:0] Mz;
    logic        invalid_flag, divzero_flag, overflow_flag;
    logic        underflow_flag, inexact_flag, zero_flag;

    int n_vec = 0;
    int n_err = 0;

    fp_div_seq #(.EXP_W(8), .MAN_W(23), .BIAS(127)) dut (
        .CLK(CLK), .RST(RST), .start(start),
        .Sx(Sx), .Sy(Sy), .Ex(Ex), .Ey(Ey), .Mx(Mx), .My(My), .R_mode(R_mode),
        .busy(busy), .done(done), .Sz(Sz), .Ez(Ez), .Mz(Mz),
        .invalid_flag(invalid_flag), .divzero_flag(divzero_flag),
        .overflow_flag(overflow_flag), .underflow_flag(underflow_flag),
        .inexact_flag(inexact_flag), .zero_flag(zero_flag)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        sx;
        logic [7:0]  ex;
        logic [22:0] mx;
        logic        sy;
        logic [7:0]  ey;
        logic [22:0] my;
        logic [1:0]  rm;
        logic [31:0] z;
        logic [5:0]  f;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic sx, input logic [7:0] ex, input logic [22:0] mx,
                                input logic sy, input logic [7:0] ey, input logic [22:0] my,
                                input logic [1:0] rm, input logic [31:0] z, input logic [5:0] f,
                                input int lat);
        vec_t v;
        v.sx = sx; v.ex = ex; v.mx = mx; v.sy = sy; v.ey = ey; v.my = my;
        v.rm = rm; v.z = z; v.f = f; v.lat = lat;
        tbl.push_back(v);
    endfunction

    function automatic logic [5:0] dut_flags();
        return {invalid_flag, divzero_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact integer quotient with remainder-based rounding.
    // Flags are {invalid, divzero, overflow, underflow, inexact, zero}.
    function automatic void model(input logic sx, input logic [7:0] ex, input logic [22:0] mx,
                                  input logic sy, input logic [7:0] ey, input logic [22:0] my,
                                  input logic [1:0] rm,
                                  output logic [31:0] z, output logic [5:0] f, output int lat);
        bit xz, xi, xn, yz, yi, yn, sz, inc, to_inf;
        longint a, b, num, sig, rem;
        int e;
        xz = (ex == 0);   xi = (ex == 255) && (mx == 0); xn = (ex == 255) && (mx != 0);
        yz = (ey == 0);   yi = (ey == 255) && (my == 0); yn = (ey == 255) && (my != 0);
        sz = sx ^ sy;
        f = '0;
        lat = 2;
        if (xn || yn) begin
            z = 32'h7FC00000;
            f[5] = (xn && !mx[22]) || (yn && !my[22]);
        end else if ((xz && yz) || (xi && yi)) begin
            z = 32'h7FC00000;
            f[5] = 1'b1;
        end else if (yz && !xi) begin
            z = {sz, 31'h7F800000};
            f[4] = 1'b1;
        end else if (xi) begin
            z = {sz, 31'h7F800000};
        end else if (xz || yi) begin
            z = {sz, 31'h0};
            f[0] = 1'b1;
        end else begin
            lat = 28;
            a = (64'd1 << 23) | longint'(mx);
            b = (64'd1 << 23) | longint'(my);
            e = int'(ex) - int'(ey) + 127;
            if (a >= b) num = a << 23;
            else begin
                num = a << 24;
                e = e - 1;
            end
            sig = num / b;
            rem = num % b;
            case (rm)
                2'b00:   inc = (2 * rem > b) || ((2 * rem == b) && sig[0]);
                2'b01:   inc = 1'b0;
                2'b10:   inc = (rem != 0) && !sz;
                default: inc = (rem != 0) && sz;
            endcase
            sig = sig + longint'(inc);
            if (sig == (64'd1 << 24)) begin
                sig = 64'd1 << 23;
                e = e + 1;
            end
            f[1] = (rem != 0);
            if (e >= 255) begin
                to_inf = (rm == 2'b00) || (rm == 2'b10 && !sz) || (rm == 2'b11 && sz);
                z = to_inf ? {sz, 31'h7F800000} : {sz, 31'h7F7FFFFF};
                f[3] = 1'b1;
                f[1] = 1'b1;
            end else if (e <= 0) begin
                z = {sz, 31'h0};
                f[2] = 1'b1;
                f[1] = 1'b1;
                f[0] = 1'b1;
            end else begin
                z = {sz, e[7:0], sig[22:0]};
            end
        end
    endfunction

    // One complete transaction; latency counts negedges after the start edge.
    task automatic run_op(input logic sx, input logic [7:0] ex, input logic [22:0] mx,
                          input logic sy, input logic [7:0] ey, input logic [22:0] my,
                          input logic [1:0] rm,
                          output logic [31:0] z, output logic [5:0] f, output int lat,
                          output logic busy1);
        @(negedge CLK);
        Sx = sx; Ex = ex; Mx = mx; Sy = sy; Ey = ey; My = my; R_mode = rm;
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        lat = 0;
        busy1 = 1'b0;
        while (lat < 100) begin
            @(negedge CLK);
            lat++;
            if (lat == 1) busy1 = busy;
            if (done) break;
        end
        z = {Sz, Ez, Mz};
        f = dut_flags();
    endtask

    initial begin
        logic [31:0] z, ez;
        logic [5:0]  f, ef;
        int          lat, elat, cnt;
        logic        b1, seen;
        logic        rsx, rsy;
        logic [7:0]  rex, rey;
        logic [22:0] rmx, rmy;
        logic [1:0]  rrm;

        RST = 1'b1; start = 1'b0; Sx = 0; Sy = 0; Ex = 0; Ey = 0; Mx = 0; My = 0; R_mode = 0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("reset_state", {busy, done, Sz, Ez, Mz, dut_flags()}, 64'd0);

        add(0, 129, 23'h400000, 0, 128, 23'h000000, 2'd0, 32'h40400000, 6'b000000, 28);
        add(0, 127, 23'h000000, 0, 128, 23'h400000, 2'd0, 32'h3EAAAAAB, 6'b000010, 28);
        add(0, 127, 23'h000000, 0, 128, 23'h400000, 2'd1, 32'h3EAAAAAA, 6'b000010, 28);
        add(1, 127, 23'h000000, 0, 128, 23'h400000, 2'd3, 32'hBEAAAAAB, 6'b000010, 28);
        add(0, 127, 23'h000000, 0, 0,   23'h000000, 2'd0, 32'h7F800000, 6'b010000, 2);
        add(0, 0,   23'h000000, 0, 0,   23'h000000, 2'd0, 32'h7FC00000, 6'b100000, 2);
        add(0, 254, 23'h7FFFFF, 0, 126, 23'h000000, 2'd0, 32'h7F800000, 6'b001010, 28);
        add(0, 254, 23'h7FFFFF, 0, 126, 23'h000000, 2'd1, 32'h7F7FFFFF, 6'b001010, 28);
        add(1, 254, 23'h7FFFFF, 0, 126, 23'h000000, 2'd2, 32'hFF7FFFFF, 6'b001010, 28);
        add(1, 254, 23'h7FFFFF, 0, 126, 23'h000000, 2'd3, 32'hFF800000, 6'b001010, 28);
        add(0, 1,   23'h000000, 1, 200, 23'h000000, 2'd0, 32'h80000000, 6'b000111, 28);
        add(0, 255, 23'h000001, 0, 127, 23'h000000, 2'd0, 32'h7FC00000, 6'b100000, 2);
        add(0, 255, 23'h400000, 0, 127, 23'h000000, 2'd0, 32'h7FC00000, 6'b000000, 2);
        add(0, 255, 23'h000000, 1, 255, 23'h000000, 2'd0, 32'h7FC00000, 6'b100000, 2);
        add(0, 255, 23'h000000, 1, 128, 23'h000000, 2'd0, 32'hFF800000, 6'b000000, 2);
        add(0, 255, 23'h000000, 1, 0,   23'h000000, 2'd0, 32'hFF800000, 6'b000000, 2);
        add(1, 0,   23'h000000, 0, 129, 23'h200000, 2'd0, 32'h80000000, 6'b000001, 2);
        add(0, 128, 23'h400000, 0, 255, 23'h000000, 2'd0, 32'h00000000, 6'b000001, 2);
        add(0, 127, 23'h000000, 0, 127, 23'h000000, 2'd0, 32'h3F800000, 6'b000000, 28);

        foreach (tbl[i]) begin
            run_op(tbl[i].sx, tbl[i].ex, tbl[i].mx, tbl[i].sy, tbl[i].ey, tbl[i].my, tbl[i].rm,
                   z, f, lat, b1);
            check($sformatf("tbl%0d_result", i), {26'd0, z, f}, {26'd0, tbl[i].z, tbl[i].f});
            check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
            check($sformatf("tbl%0d_busy", i), 64'(b1), 64'd1);
        end

        // Second start mid-divide must be ignored
        @(negedge CLK);
        Sx = 0; Ex = 129; Mx = 23'h400000; Sy = 0; Ey = 128; My = 0; R_mode = 0;
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        cnt = 0;
        while (cnt < 100) begin
            @(negedge CLK);
            cnt++;
            if (cnt == 10) begin
                Ex = 127; Mx = 0; Ey = 0; My = 0; Sx = 1; R_mode = 2'd1;
                start = 1'b1;
            end
            if (cnt == 11) start = 1'b0;
            if (done) break;
        end
        check("hs_latency", 64'(cnt), 64'd28);
        check("hs_result", {26'd0, Sz, Ez, Mz, dut_flags()}, {26'd0, 32'h40400000, 6'b000000});
        @(negedge CLK);
        check("hs_done_pulse", {62'd0, done, busy}, 64'd0);

        // Reset mid-operation aborts without a done pulse
        @(negedge CLK);
        Sx = 0; Ex = 127; Mx = 0; Sy = 0; Ey = 128; My = 23'h400000; R_mode = 0;
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge CLK);
            if (done) seen = 1'b1;
        end
        RST = 1'b1;
        #1;
        check("rst_outputs", {busy, done, Sz, Ez, Mz, dut_flags()}, 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (done) seen = 1'b1;
        end
        check("rst_no_done", 64'(seen), 64'd0);
        run_op(0, 127, 23'h0, 0, 128, 23'h400000, 2'd0, z, f, lat, b1);
        check("rst_recover_result", {26'd0, z, f}, {26'd0, 32'h3EAAAAAB, 6'b000010});
        check("rst_recover_latency", 64'(lat), 64'd28);

        // Randomized operands against the reference model
        for (int i = 0; i < 300; i++) begin
            rsx = 1'($urandom); rsy = 1'($urandom);
            rrm = 2'($urandom);
            rmx = 23'($urandom); rmy = 23'($urandom);
            case ($urandom_range(0, 9))
                0:       rex = 8'd0;
                1:       rex = 8'd255;
                default: rex = 8'($urandom_range(1, 254));
            endcase
            case ($urandom_range(0, 9))
                0:       rey = 8'd0;
                1:       rey = 8'd255;
                default: rey = 8'($urandom_range(1, 254));
            endcase
            if (rex == 8'd255 && $urandom_range(0, 1) == 0) rmx = '0;
            if (rey == 8'd255 && $urandom_range(0, 1) == 0) rmy = '0;
            model(rsx, rex, rmx, rsy, rey, rmy, rrm, ez, ef, elat);
            run_op(rsx, rex, rmx, rsy, rey, rmy, rrm, z, f, lat, b1);
            check($sformatf("rnd%0d_result", i), {26'd0, z, f}, {26'd0, ez, ef});
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(elat));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
